// File: rtl/memory_access_master_pkg.sv
// Shared definitions for the memory access master: controller state
// encoding, default burst-length field width and bytes per memory word.
package memory_access_pkg;

  localparam int BURST_W    = 3;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/memory_access_master_if.sv
// Request / write-data / response bus between a client and the memory
// access master. The master sits on the slave modport of this bus.
interface memory_access_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_W    = 3
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [DATA_WIDTH-1:0] req_address_i;
  logic [BURST_W-1:0]    req_len_i;

  logic                  wdata_valid_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  wdata_ready_o;

  logic                  resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic                  resp_last_o;
  logic                  resp_error_o;

  modport slave (
    input  req_valid_i, req_write_i, req_address_i, req_len_i,
    input  wdata_valid_i, wdata_i,
    output req_ready_o, wdata_ready_o,
    output resp_valid_o, resp_data_o, resp_last_o, resp_error_o
  );

  modport master (
    output req_valid_i, req_write_i, req_address_i, req_len_i,
    output wdata_valid_i, wdata_i,
    input  req_ready_o, wdata_ready_o,
    input  resp_valid_o, resp_data_o, resp_last_o, resp_error_o
  );
endinterface

// File: rtl/memory_access_master_burst_address_counter.sv
// Burst address generator: holds the current byte address and the number
// of beats still to go. Addresses step one word at a time and wrap to 0 at
// the end of the memory.
module burst_address_counter #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [BURST_W-1:0]    len_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] addr_o,
  output logic                  last_o
);
  import memory_access_pkg::*;

  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * WORD_BYTES);
  localparam logic [DATA_WIDTH-1:0] ADDR_STEP  = DATA_WIDTH'(WORD_BYTES);

  logic [DATA_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [BURST_W-1:0]    remain_q, remain_d;

  // Next address/count: load wins over advance; advance wraps at the top.
  always_comb begin
    addr_inc = addr_q + ADDR_STEP;
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = addr_i;
      remain_d = len_i;
    end else if (advance_i) begin
      addr_d   = (addr_inc >= ADDR_LIMIT) ? '0 : addr_inc;
      remain_d = remain_q - BURST_W'(1);
    end
  end

  // Address and remaining-beat registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == '0);

endmodule

// File: rtl/memory_access_master.sv
// Burst memory access master: accepts read/write burst requests, drives a
// single-port memory with combinational read data, and returns one response
// beat per read word, one completion beat per write burst, or one error beat
// for a misaligned / out-of-range start address.
module memory_access_master #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_W      = memory_access_pkg::BURST_W
) (
  input  logic                  clk,
  input  logic                  reset,
  memory_access_master_if.slave bus,
  output logic                  mem_write_enable_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  output logic                  busy_o
);
  import memory_access_pkg::*;

  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * WORD_BYTES);

  state_e                state_q;
  logic                  resp_valid_q, resp_last_q, resp_error_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic                  req_ready, accept, addr_bad;
  logic                  in_write, in_read, write_beat;
  logic [DATA_WIDTH-1:0] cur_addr;
  logic                  cnt_last;

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign accept     = bus.req_valid_i && req_ready;
  assign addr_bad   = (bus.req_address_i[1:0] != 2'b00) || (bus.req_address_i >= ADDR_LIMIT);
  assign in_write   = (state_q == ST_WRITE);
  assign in_read    = (state_q == ST_READ);
  assign write_beat = in_write && bus.wdata_valid_i;

  burst_address_counter #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .BURST_W      (BURST_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept && !addr_bad),
    .addr_i    (bus.req_address_i),
    .len_i     (bus.req_len_i),
    .advance_i (write_beat || in_read),
    .addr_o    (cur_addr),
    .last_o    (cnt_last)
  );

  // Controller FSM; response beats are registered so each is a single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (addr_bad) begin
              // Error beat is raised on entry so it is visible during ERROR.
              state_q      <= ST_ERROR;
              resp_valid_q <= 1'b1;
              resp_last_q  <= 1'b1;
              resp_error_q <= 1'b1;
            end else begin
              state_q <= bus.req_write_i ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (write_beat && cnt_last) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_last_q  <= 1'b1;
          end
        end
        ST_READ: begin
          // Read data is captured here and presented one cycle later.
          resp_valid_q <= 1'b1;
          resp_data_q  <= mem_read_data_i;
          resp_last_q  <= cnt_last;
          if (cnt_last) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RESP:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.wdata_ready_o = in_write;
  assign bus.resp_valid_o  = resp_valid_q;
  assign bus.resp_data_o   = resp_data_q;
  assign bus.resp_last_o   = resp_last_q;
  assign bus.resp_error_o  = resp_error_q;

  assign mem_write_enable_o = write_beat;
  assign mem_write_data_o   = write_beat ? bus.wdata_i : '0;
  assign mem_address_o      = (in_write || in_read) ? cur_addr : '0;
  assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: doc/memory_access_master.md
MEMORY_ACCESS_MASTER -- requirements
Module: memory_access_master

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32, number of words in the memory_system target.
REQ-002 Parameter DATA_WIDTH, default 32, width of data and byte addresses.
REQ-003 Parameter BURST_W, default 3, width of the burst-length field; beats per request = req_len_i+1 (1..8).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid_i  input  1  request offered; req_ready_o  output  1  request accepted when both high.
REQ-007 req_write_i  input  1  1 = write burst, 0 = read burst.
REQ-008 req_address_i  input  DATA_WIDTH  byte address of first beat; req_len_i  input  BURST_W  beats minus one.
REQ-009 wdata_valid_i  input  1, wdata_i  input  DATA_WIDTH, wdata_ready_o  output  1  write-beat handshake.
REQ-010 resp_valid_o  output  1, resp_data_o  output  DATA_WIDTH, resp_last_o  output  1, resp_error_o  output  1  response beat; no backpressure.
REQ-011 mem_write_enable_o  output  1, mem_write_data_o  output  DATA_WIDTH, mem_address_o  output  DATA_WIDTH  drive memory_system write_enable, write_data, address.
REQ-012 mem_read_data_i  input  DATA_WIDTH  memory_system read data, combinational from mem_address_o.
REQ-013 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, WRITE, READ, RESP, ERROR.
REQ-015 req_ready_o SHALL equal (state==IDLE) and not reset.
REQ-016 IDLE, on accept: latch address, beat count, direction; go ERROR if address[1:0]!=0 or address >= MEMORY_DEPTH*4, else WRITE or READ.
REQ-017 WRITE: wdata_ready_o=1; each cycle with wdata_valid_i, mem_write_enable_o=1, mem_write_data_o=wdata_i, mem_address_o=current address (combinational), then address advances.
REQ-018 WRITE with wdata_valid_i low: mem_write_enable_o=0, address and count hold; no timeout.
REQ-019 After final write beat: RESP for exactly one cycle with resp_valid_o=1, resp_last_o=1, resp_data_o=0, resp_error_o=0, then IDLE.
REQ-020 READ: one address per cycle on mem_address_o, mem_write_enable_o=0; mem_read_data_i registered into resp_data_o with resp_valid_o=1 on the following cycle.
REQ-021 Read throughput one beat per cycle; beat n response appears cycle n+1 after READ entry; final beat has resp_last_o=1; state then IDLE (RESP not used for reads).
REQ-022 Address advance: next = (current+4) mod (MEMORY_DEPTH*4); bursts wrap to address 0, no error.
REQ-023 ERROR: one cycle resp_valid_o=1, resp_error_o=1, resp_last_o=1, resp_data_o=0; no memory access; then IDLE; write-data beats not consumed.
REQ-024 Outside WRITE/READ: mem_write_enable_o=0, mem_address_o=0, mem_write_data_o=0, wdata_ready_o=0.
REQ-025 resp_valid_o SHALL be a one-cycle pulse per beat; low in all other cycles.

Reset
REQ-026 Reset SHALL force IDLE and clear all registers: resp_* =0, busy_o=0, mem_*_o=0, wdata_ready_o=0, req_ready_o=0 while asserted.
REQ-027 Reset mid-burst SHALL abort immediately: no further memory writes, no pending response emitted; req_ready_o=1 first cycle after release.

Structure
REQ-028 Package memory_access_pkg SHALL hold state encoding, BURST_W, WORD_BYTES=4 constant.
REQ-029 Sub-module burst_address_counter SHALL hold current address and remaining-beat count (load, advance, wrap, last flag).
REQ-030 RTL SHALL connect directly to memory_system (MEMORY_DEPTH=32, DATA_WIDTH=32) in the bench.

Verification
REQ-031 Single write 0xDEADBEEF to 0x08, len 0 -> one mem write at 0x08, RESP pulse last=1 error=0; read back 0x08 len 0 -> resp_data 0xDEADBEEF, last=1.
REQ-032 Write burst len 3 at 0x10, data 1,2,3,4 with wdata_valid low two cycles mid-burst -> writes at 0x10,0x14,0x18,0x1C only on valid cycles; read burst returns 1,2,3,4 on four consecutive cycles, last on 4th.
REQ-033 Read burst len 3 at 0x78 -> addresses 0x78,0x7C,0x00,0x04 (wrap), no error.
REQ-034 Request at 0x80 and at 0x06 -> single ERROR pulse each, mem_write_enable_o never high.
REQ-035 Reset asserted during 3rd beat of 8-beat write -> no writes after reset, no response, IDLE with req_ready_o=1 after release.
